// File: rtl/axi_rr_txn_arbiter.sv
// Round-robin owner arbiter for a shared AXI channel: a grant is held until txn_done,
// or until the watchdog forces release, then one dead cycle precedes the next grant.
module axi_rr_txn_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned IDX_W          = $clog2(NUM_MASTERS),
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   txn_done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid,
    output logic                   timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                                                  : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       w_ptr_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_d;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       w_grant_idx_d;
    logic                   r_grant_valid;
    logic                   w_grant_valid_d;
    logic                   r_timeout;
    logic                   w_timeout_d;

    logic                   w_any_req;
    logic                   w_sel_found;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [NUM_MASTERS-1:0] w_sel_onehot;
    logic                   w_wd_hit;
    logic                   w_release;

    assign w_any_req = |req;
    assign w_wd_hit  = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_release = txn_done || w_wd_hit;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        w_sel_found = 1'b0;
        w_cand      = '0;
        w_sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            w_cand = IDX_W'((32'(r_ptr) + i) % NUM_MASTERS);
            if (!w_sel_found && req[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
        w_sel_onehot            = '0;
        w_sel_onehot[w_sel_idx] = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_any_req) w_state_d = StGrant;
            StGrant:   if (w_release) w_state_d = StRelease;
            StRelease: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_grant_d       = r_grant;
        w_grant_idx_d   = r_grant_idx;
        w_grant_valid_d = r_grant_valid;
        w_timeout_d     = 1'b0;
        w_ptr_d         = r_ptr;
        w_cnt_d         = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_grant_d       = w_sel_onehot;
                    w_grant_idx_d   = w_sel_idx;
                    w_grant_valid_d = 1'b1;
                    w_cnt_d         = '0;
                end
            end
            StGrant: begin
                w_cnt_d = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                if (w_release) begin
                    w_grant_d       = '0;
                    w_grant_valid_d = 1'b0;
                    w_ptr_d         = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;
                    // A real completion in the same cycle suppresses the timeout flag.
                    w_timeout_d     = !txn_done;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_ptr         <= w_ptr_d;
            r_cnt         <= w_cnt_d;
            r_grant       <= w_grant_d;
            r_grant_idx   <= w_grant_idx_d;
            r_grant_valid <= w_grant_valid_d;
            r_timeout     <= w_timeout_d;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_axi_rr_txn_arbiter.sv
// Directed bench for axi_rr_txn_arbiter: per-cycle expected outputs are queued as stimulus
// is applied and compared after each rising edge; a second instance has the watchdog off.
module tb_axi_rr_txn_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic [1:0] req;
    logic       txn_done;
    logic [1:0] grant;
    logic       grant_idx;
    logic       grant_valid;
    logic       timeout;

    logic [1:0] req_nt;
    logic       txn_done_nt;
    logic [1:0] grant_nt;
    logic       grant_idx_nt;
    logic       grant_valid_nt;
    logic       timeout_nt;
    logic       nt_timeout_seen = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0] g;
        logic       i;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];

    always #5 ACLK = ~ACLK;

    axi_rr_txn_arbiter #(
        .NUM_MASTERS   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .req        (req),
        .txn_done   (txn_done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    axi_rr_txn_arbiter #(
        .NUM_MASTERS   (2),
        .TIMEOUT_CYCLES(0)
    ) dut_nt (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .req        (req_nt),
        .txn_done   (txn_done_nt),
        .grant      (grant_nt),
        .grant_idx  (grant_idx_nt),
        .grant_valid(grant_valid_nt),
        .timeout    (timeout_nt)
    );

    always @(posedge ACLK) begin
        if (timeout_nt === 1'b1) nt_timeout_seen <= 1'b1;
    end

    // Queue the expected outputs, clock once, then pop and compare.
    task automatic tick(input logic [1:0] g, input logic i, input logic v, input logic t,
                        input string tag);
        exp_t e;
        exp_t got;
        exp_t obs;
        e.g = g;
        e.i = i;
        e.v = v;
        e.t = t;
        exp_q.push_back(e);
        @(posedge ACLK);
        #1;
        got = exp_q.pop_front();
        obs = {grant, grant_idx, grant_valid, timeout};
        n_checks++;
        assert (obs === got) else begin
            n_errors++;
            $error("FAIL %s: observed grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
                   tag, obs.g, obs.i, obs.v, obs.t, got.g, got.i, got.v, got.t);
        end
        n_checks++;
        assert ((grant_valid === |grant) && (grant !== 2'b11)) else begin
            n_errors++;
            $error("FAIL %s_invariant: observed grant=%b valid=%b, expected one-hot/zero with valid=|grant",
                   tag, grant, grant_valid);
        end
    endtask

    // One granted transaction of 'hold' cycles, then release and the dead cycle.
    task automatic grant_txn(input logic [1:0] g, input logic i, input int hold,
                             input string tag);
        tick(g, i, 1'b1, 1'b0, tag);
        for (int c = 1; c < hold; c++) tick(g, i, 1'b1, 1'b0, tag);
        txn_done = 1'b1;
        tick(2'b00, i, 1'b0, 1'b0, {tag, "_rel"});
        txn_done = 1'b0;
        tick(2'b00, i, 1'b0, 1'b0, {tag, "_dead"});
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        assert ({grant, grant_idx, grant_valid, timeout} === 5'b0) else begin
            n_errors++;
            $error("FAIL %s: observed grant=%b idx=%0d valid=%b timeout=%b, expected all zero",
                   tag, grant, grant_idx, grant_valid, timeout);
        end
    endtask

    task automatic check_nt(input string tag);
        n_checks++;
        assert ({grant_nt, grant_idx_nt, grant_valid_nt, nt_timeout_seen} === 5'b01_0_1_0) else begin
            n_errors++;
            $error("FAIL %s: observed grant=%b idx=%0d valid=%b timeout_seen=%b, expected 01/0/1/0",
                   tag, grant_nt, grant_idx_nt, grant_valid_nt, nt_timeout_seen);
        end
    endtask

    initial begin
        ARESETN     = 1'b0;
        req         = 2'b11;
        txn_done    = 1'b0;
        req_nt      = 2'b01;
        txn_done_nt = 1'b0;

        #2;
        check_zero("reset_async");
        repeat (2) @(posedge ACLK);
        #1;
        check_zero("reset_held");
        ARESETN = 1'b1;

        // Fairness with both masters requesting, 3-cycle transactions.
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) grant_txn(2'b01, 1'b0, 3, "fair_m0");
            else            grant_txn(2'b10, 1'b1, 3, "fair_m1");
        end

        // Single requester, 5-cycle transactions, re-granted while req persists.
        req = 2'b10;
        grant_txn(2'b10, 1'b1, 5, "single_a");
        grant_txn(2'b10, 1'b1, 5, "single_b");

        // Leave ptr at 1, then a stray txn_done in IDLE must not move it.
        req = 2'b01;
        grant_txn(2'b01, 1'b0, 2, "pre_stray");
        req      = 2'b00;
        txn_done = 1'b1;
        tick(2'b00, 1'b0, 1'b0, 1'b0, "stray_idle");
        txn_done = 1'b0;
        tick(2'b00, 1'b0, 1'b0, 1'b0, "stray_after");
        req = 2'b11;
        grant_txn(2'b10, 1'b1, 2, "post_stray");

        // Watchdog: grant held 16 cycles even with req dropped, then timeout pulse.
        req = 2'b01;
        tick(2'b01, 1'b0, 1'b1, 1'b0, "wd_grant");
        req = 2'b00;
        for (int c = 1; c < 16; c++) tick(2'b01, 1'b0, 1'b1, 1'b0, "wd_hold");
        tick(2'b00, 1'b0, 1'b0, 1'b1, "wd_fire");
        tick(2'b00, 1'b0, 1'b0, 1'b0, "wd_pulse_end");
        tick(2'b00, 1'b0, 1'b0, 1'b0, "wd_idle");
        check_nt("nowd_held_a");

        // txn_done in the cycle the watchdog would fire: clean release, no timeout.
        req = 2'b10;
        tick(2'b10, 1'b1, 1'b1, 1'b0, "col_grant");
        for (int c = 1; c < 16; c++) tick(2'b10, 1'b1, 1'b1, 1'b0, "col_hold");
        txn_done = 1'b1;
        tick(2'b00, 1'b1, 1'b0, 1'b0, "col_release");
        txn_done = 1'b0;
        tick(2'b00, 1'b1, 1'b0, 1'b0, "col_dead");
        check_nt("nowd_held_b");

        // Reset in the middle of a grant to master 1.
        tick(2'b10, 1'b1, 1'b1, 1'b0, "mid_grant");
        tick(2'b10, 1'b1, 1'b1, 1'b0, "mid_hold");
        ARESETN = 1'b0;
        #2;
        check_zero("mid_reset_async");
        req = 2'b11;
        @(posedge ACLK);
        #1;
        check_zero("mid_reset_held");
        ARESETN = 1'b1;
        tick(2'b01, 1'b0, 1'b1, 1'b0, "post_reset_grant");
        tick(2'b01, 1'b0, 1'b1, 1'b0, "post_reset_hold");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
